// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if
//   Bundles the byte-side enqueue port and the serial/status outputs of
//   uart_transmitter. clk and rst stay plain module ports.
//   master: the producer/observer (drives Tx_Data, Tx_Load, BIST_Mode).
//   slave : the transmitter (drives Tx, Tx_Busy and the FIFO flags).
//   Signals:
//     Tx_Data       byte to enqueue, sampled when Tx_Load=1
//     Tx_Load       single-cycle write strobe
//     BIST_Mode     1 freezes enqueue and frame start
//     Tx            serial line, idle high
//     Tx_Busy       transmitter FSM not idle
//     FIFO_Empty    buffer holds no entries
//     FIFO_Full     buffer holds FIFO_ENTRIES entries
//     FIFO_Overflow sticky: a write was dropped
interface uart_transmitter_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] Tx_Data;
  logic                 Tx_Load;
  logic                 BIST_Mode;
  logic                 Tx;
  logic                 Tx_Busy;
  logic                 FIFO_Empty;
  logic                 FIFO_Full;
  logic                 FIFO_Overflow;

  modport master (
    output Tx_Data, Tx_Load, BIST_Mode,
    input  Tx, Tx_Busy, FIFO_Empty, FIFO_Full, FIFO_Overflow
  );

  modport slave (
    input  Tx_Data, Tx_Load, BIST_Mode,
    output Tx, Tx_Busy, FIFO_Empty, FIFO_Full, FIFO_Overflow
  );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Buffered UART transmitter: a small circular TX buffer feeding a
//   START / DATA (LSB first) / optional PARITY / STOP serializer. Each bit is
//   held CLKS_PER_BIT clocks. Frames run back-to-back while the buffer has
//   entries. BIST_Mode blocks enqueue and new frames but lets a running frame
//   finish.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  uart_transmitter_if.slave (Tx_Data/Tx_Load/BIST_Mode in,
//          Tx/Tx_Busy/FIFO_Empty/FIFO_Full/FIFO_Overflow out)
module uart_transmitter #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_WIDTH   = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic               clk,
  input  logic               rst,
  uart_transmitter_if.slave  bus
);

  localparam int FIFO_ENTRIES = 2**FIFO_WIDTH;
  localparam int CW           = FIFO_WIDTH + 1;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_ENTRIES);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  logic [DATA_BITS-1:0]  mem_q [FIFO_ENTRIES];
  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, full_q;
  logic                  ovf_q, ovf_d;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;

  logic                  last_tick;
  logic                  can_start;
  logic                  buf_full;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;

  assign last_tick = (tick_q == LAST_TICK);
  assign can_start = (count_q != '0) && !bus.BIST_Mode;
  assign buf_full  = (count_q == FULL_CNT);

  // Serializer next state. pop marks the cycle the head entry is consumed;
  // it may only happen from IDLE or on the final STOP cycle.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_start) pop = 1'b1;
      end
      START: begin
        if (last_tick) begin
          state_d = DATA;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (last_tick) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      PARITY: begin
        if (last_tick) begin
          state_d = STOP;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (last_tick) begin
          tick_d = '0;
          if (can_start) pop = 1'b1;
          else           state_d = IDLE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading a new frame overrides whatever the case above chose.
    if (pop) begin
      state_d = START;
      tick_d  = '0;
      bit_d   = '0;
      shift_d = mem_q[rd_ptr_q];
      par_d   = parity_of(mem_q[rd_ptr_q]);
    end
  end

  // Tx is registered from the current state, so the line lags the FSM by
  // one clock; every bit still lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  // A full buffer still accepts a write when the head is popped that cycle.
  always_comb begin
    wr_en    = bus.Tx_Load && !bus.BIST_Mode && (!buf_full || pop);
    drop     = bus.Tx_Load && !bus.BIST_Mode && buf_full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (drop)     ovf_d = 1'b1;
    else if (pop) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == FULL_CNT);
      ovf_q    <= ovf_d;
    end
  end

  // Buffer storage carries data only; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= bus.Tx_Data;
  end

  assign bus.Tx            = tx_q;
  assign bus.Tx_Busy       = (state_q != IDLE);
  assign bus.FIFO_Empty    = empty_q;
  assign bus.FIFO_Full     = full_q;
  assign bus.FIFO_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;
  localparam int DB    = 8;
  localparam int FW    = 2;
  localparam int CPB   = 16;
  localparam int NENT  = 4;
  localparam int FRAME = (2 + DB + 1) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_transmitter_if #(.DATA_BITS(DB)) bus ();
  uart_transmitter_if #(.DATA_BITS(DB)) obus ();

  uart_transmitter #(
    .DATA_BITS(DB), .FIFO_WIDTH(FW), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  uart_transmitter #(
    .DATA_BITS(DB), .FIFO_WIDTH(FW), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .PARITY_ODD(1)
  ) dut_odd (
    .clk(clk), .rst(rst), .bus(obus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: queue of pending bytes plus the frame being sent,
  // tracked as "edges elapsed since the pop".
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_age    = 0;
  logic [7:0] m_byte   = '0;
  bit         m_ovf    = 1'b0;
  bit         m_tx     = 1'b1;

  logic       o_load = 1'b0;
  logic [7:0] o_data = '0;

  // Serial frame bit idx: 0 start, 1..8 data LSB first, 9 parity, 10 stop.
  function automatic bit frame_bit(input logic [7:0] b, input int idx, input bit odd);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return b[idx-1];
    if (idx == DB + 1) return ($countones(b) % 2 == 1) ^ odd;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_model(input bit l, input logic [7:0] d, input bit b, input bit r);
    bit pop, endf, full_before;
    if (r) begin
      mq.delete();
      m_active = 1'b0;
      m_age    = 0;
      m_ovf    = 1'b0;
      m_tx     = 1'b1;
      return;
    end
    m_tx        = m_active ? frame_bit(m_byte, m_age / CPB, 1'b0) : 1'b1;
    endf        = m_active && (m_age == FRAME - 1);
    pop         = (!m_active || endf) && (mq.size() > 0) && !b;
    full_before = (mq.size() == NENT);
    if (pop) begin
      m_byte   = mq.pop_front();
      m_active = 1'b1;
      m_age    = 0;
      m_ovf    = 1'b0;
    end else if (endf) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_age++;
    end
    if (l && !b) begin
      if (!full_before || pop) mq.push_back(d);
      else                     m_ovf = 1'b1;
    end
  endtask

  task automatic cyc(input bit l, input logic [7:0] d, input bit b, input bit r);
    @(negedge clk);
    bus.Tx_Load    = l;
    bus.Tx_Data    = d;
    bus.BIST_Mode  = b;
    rst            = r;
    obus.Tx_Load   = o_load;
    obus.Tx_Data   = o_data;
    obus.BIST_Mode = 1'b0;
    @(posedge clk);
    step_model(l, d, b, r);
    #1;
    chk("tx",    bus.Tx,            m_tx);
    chk("busy",  bus.Tx_Busy,       m_active);
    chk("empty", bus.FIFO_Empty,    mq.size() == 0);
    chk("full",  bus.FIFO_Full,     mq.size() == NENT);
    chk("ovf",   bus.FIFO_Overflow, m_ovf);
  endtask

  initial begin
    int busy_n;
    int first0;
    logic hist [0:199];
    logic [10:0] got, want;
    logic [7:0] a5;

    bus.Tx_Load = 1'b0; bus.Tx_Data = '0; bus.BIST_Mode = 1'b0;
    obus.Tx_Load = 1'b0; obus.Tx_Data = '0; obus.BIST_Mode = 1'b0;

    // Reset, then idle
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    repeat (20) cyc(0, 8'h00, 0, 0);
    chk("idle_tx", bus.Tx, 1'b1);
    chk("idle_empty", bus.FIFO_Empty, 1'b1);

    // Single 0xA5 frame, decoded from the line at mid-bit
    a5 = 8'hA5;
    cyc(1, a5, 0, 0);
    busy_n = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(0, 8'h00, 0, 0);
      hist[i] = bus.Tx;
      busy_n += int'(bus.Tx_Busy);
    end
    first0 = -1;
    for (int i = 0; i < 200; i++) if (first0 < 0 && hist[i] === 1'b0) first0 = i;
    chk("a5_start_latency", first0, 1);
    chk("a5_busy_cycles", busy_n, FRAME);
    got = '0;
    if (first0 >= 0 && first0 + 10 * CPB + 8 < 200)
      for (int k = 0; k < 11; k++) got[k] = hist[first0 + k * CPB + 8];
    want = {1'b1, 1'b0, a5, 1'b0};
    chk("a5_frame_bits", got, want);
    chk("a5_low_before_end", hist[first0 + FRAME - 1 - 8], 1'b1);

    // Six consecutive loads: one popped, four buffered, one dropped
    for (int i = 0; i < 6; i++) cyc(1, 8'($urandom), 0, 0);
    chk("burst_full", bus.FIFO_Full, 1'b1);
    chk("burst_ovf", bus.FIFO_Overflow, 1'b1);
    repeat (5 * FRAME + 20) cyc(0, 8'h00, 0, 0);
    chk("burst_done_empty", bus.FIFO_Empty, 1'b1);

    // BIST blocks the enqueue path
    repeat (3) cyc(1, 8'h3C, 1, 0);
    repeat (20) cyc(0, 8'h00, 1, 0);
    chk("bist_empty", bus.FIFO_Empty, 1'b1);
    chk("bist_tx", bus.Tx, 1'b1);
    cyc(1, 8'h3C, 0, 0);
    repeat (FRAME + 10) cyc(0, 8'h00, 0, 0);

    // BIST raised mid-frame: current frame finishes, queued entry waits
    cyc(1, 8'($urandom), 0, 0);
    cyc(1, 8'($urandom), 0, 0);
    repeat (30) cyc(0, 8'h00, 0, 0);
    repeat (FRAME + 40) cyc(1, 8'($urandom), 1, 0);
    chk("bist_hold_queued", bus.FIFO_Empty, 1'b0);
    repeat (FRAME + 10) cyc(0, 8'h00, 0, 0);

    // Reset mid-frame with two entries queued
    for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 0, 0);
    repeat (47) cyc(0, 8'h00, 0, 0);
    cyc(1, 8'hFF, 1, 1);
    chk("rst_tx", bus.Tx, 1'b1);
    chk("rst_empty", bus.FIFO_Empty, 1'b1);
    busy_n = 0;
    for (int i = 0; i < 250; i++) begin
      cyc(0, 8'h00, 0, 0);
      busy_n += int'(bus.Tx_Busy);
    end
    chk("rst_no_frames", busy_n, 0);

    // Randomized traffic: sparse then dense loads, BIST windows, rare resets
    for (int i = 0; i < 3000; i++) begin
      bit l, b, r;
      l = (i < 1500) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 7) == 0);
      b = ((i % 700) >= 600);
      r = ($urandom_range(0, 1499) == 0);
      cyc(l, 8'($urandom), b, r);
    end
    repeat (6 * FRAME) cyc(0, 8'h00, 0, 0);

    // Odd-parity instance: 0x00 -> parity 1, 0x01 -> parity 0
    o_data = 8'h00; o_load = 1'b1;
    cyc(0, 8'h00, 0, 0);
    o_load = 1'b0;
    repeat (2 + 9 * CPB + 8) cyc(0, 8'h00, 0, 0);
    chk("odd_par_00", obus.Tx, 1'b1);
    repeat (40) cyc(0, 8'h00, 0, 0);
    chk("odd_idle", obus.Tx_Busy, 1'b0);
    o_data = 8'h01; o_load = 1'b1;
    cyc(0, 8'h00, 0, 0);
    o_load = 1'b0;
    repeat (2 + 9 * CPB + 8) cyc(0, 8'h00, 0, 0);
    chk("odd_par_01", obus.Tx, 1'b0);
    repeat (40) cyc(0, 8'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame and width of Tx_Data.
REQ-002 Parameter FIFO_WIDTH, default 2: TX buffer address width; FIFO_ENTRIES = 2**FIFO_WIDTH.
REQ-003 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range is 2 or more.
REQ-004 Parameter PARITY_EN, default 1: 1 inserts one parity bit after the data bits.
REQ-005 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-006 Port clk, input, 1: sole clock; all logic SHALL be on its rising edge.
REQ-007 Port rst, input, 1: reset, synchronous, active-high.
REQ-008 Port Tx_Data, input, DATA_BITS: byte to enqueue, sampled when Tx_Load=1.
REQ-009 Port Tx_Load, input, 1: single-cycle write strobe into the TX buffer.
REQ-010 Port BIST_Mode, input, 1: 1 freezes the enqueue path and frame start.
REQ-011 Port Tx, output, 1: serial line, registered, idle high.
REQ-012 Port Tx_Busy, output, 1: 1 whenever the FSM is not in IDLE.
REQ-013 Port FIFO_Empty, output, 1: registered; 1 when the buffer count is 0.
REQ-014 Port FIFO_Full, output, 1: registered; 1 when the buffer count equals FIFO_ENTRIES.
REQ-015 Port FIFO_Overflow, output, 1: registered, sticky; a write was dropped.

Function
REQ-016 Buffer: circular, with FIFO_WIDTH-bit read/write pointers that wrap modulo FIFO_ENTRIES, plus a count of 0..FIFO_ENTRIES.
REQ-017 Write acceptance: Tx_Load=1, BIST_Mode=0, and either count<FIFO_ENTRIES or a pop occurs in the same cycle; then store at the write pointer, increment it, and update the count.
REQ-018 Dropped write: Tx_Load=1, BIST_Mode=0, buffer full, no pop this cycle; data discarded, FIFO_Overflow=1 at the next edge; pointers and count unchanged.
REQ-019 FIFO_Overflow SHALL clear at the edge where the FSM pops an entry; otherwise it holds.
REQ-020 Simultaneous write and pop: both SHALL take effect; count unchanged.
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP; a CLKS_PER_BIT cycle counter times each bit.
REQ-022 IDLE: Tx=1. If count>0 and BIST_Mode=0, pop the head into the shift register, clear the bit counter, and go to START.
REQ-023 START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-024 DATA: shift out DATA_BITS bits LSB first, each held CLKS_PER_BIT cycles; then go to PARITY if PARITY_EN=1, else STOP.
REQ-025 PARITY: Tx = XOR of the data bits XOR PARITY_ODD, held CLKS_PER_BIT cycles; then go to STOP.
REQ-026 STOP: Tx=1 for CLKS_PER_BIT cycles. At the final cycle, if count>0 and BIST_Mode=0, pop and go directly to START (no idle gap); else go to IDLE.
REQ-027 Frame length: exactly (2+DATA_BITS+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-028 Latency: write accepted at edge N while IDLE with buffer empty -> pop at edge N+1 -> Tx=0 from edge N+2.
REQ-029 BIST_Mode=1: Tx_Load ignored (no write, no overflow), no new frame started; a frame in progress SHALL complete.
REQ-030 Tx SHALL change only on clock edges and SHALL be glitch-free.

Reset
REQ-031 rst=1 at an edge: FSM to IDLE, Tx=1, Tx_Busy=0, pointers/count=0, FIFO_Empty=1, FIFO_Full=0, FIFO_Overflow=0, shift register and bit counter cleared.
REQ-032 Reset mid-frame SHALL abort the frame (Tx=1 after that edge) and flush all buffered entries.
REQ-033 rst SHALL take priority over Tx_Load and BIST_Mode.

Verification (DATA_BITS=8, FIFO_WIDTH=2, CLKS_PER_BIT=16, PARITY_EN=1)
REQ-034 Reset then idle 20 cycles -> Tx=1, Tx_Busy=0, FIFO_Empty=1, FIFO_Full=0, FIFO_Overflow=0.
REQ-035 Load 0xA5 once -> Tx=0 two edges later; bits 1,0,1,0,0,1,0,1; parity 0; stop 1; 16 cycles each; 176 cycles total; then Tx_Busy=0.
REQ-036 Tx_Load on 6 consecutive cycles -> byte1 popped, bytes 2-5 buffered, FIFO_Full=1, byte6 dropped, FIFO_Overflow=1; overflow clears at the byte2 pop; 5 frames back-to-back with no idle cycle.
REQ-037 BIST_Mode=1, load 0x3C -> FIFO_Empty stays 1, Tx stays 1, FIFO_Overflow=0; BIST_Mode=0 then load -> normal frame.
REQ-038 rst at cycle 50 of a frame with 2 entries queued -> Tx=1 next edge, FIFO_Empty=1, no further frames.
REQ-039 PARITY_ODD=1, load 0x00 -> parity bit 1; load 0x01 -> parity bit 0.
